// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its neighbours.
// The mux block imports the width defaults from here so that both blocks
// agree on the PC and instruction widths.
package fetch_unit_pkg;

  localparam int DataSizeDef = 32;
  localparam int AddrSizeDef = 10;
  localparam int TimeoutDef  = 16;

  localparam logic [AddrSizeDef-1:0] ResetPcDef = 10'h000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_VALID = 2'b10,
    S_ERR   = 2'b11
  } fetch_state_e;

  // Instructions are word aligned, so the two low PC bits must be zero.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus.
// The fetch stage is the master; the instruction memory is the slave.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int AddrSize = AddrSizeDef,
  parameter int DataSize = DataSizeDef
) ();

  logic                im_req;
  logic [AddrSize-1:0] im_addr;
  logic                im_ack;
  logic [DataSize-1:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_rdata
  );

endinterface

// File: rtl/fetch_unit_wdt.sv
// Watchdog for an outstanding fetch request.
// Counts cycles spent waiting for an acknowledge; expired_o is high while the
// count sits on the last permitted waiting cycle (TIMEOUT-1).
module fetch_wdt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Clear wins over counting so a fresh request always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no request outstanding, waiting for enable
//   S_REQ   | im_req high at im_addr = pc, waiting for im_ack
//   S_VALID | ir holds an unconsumed instruction for current_pc
//   S_ERR   | timeout or misaligned next_pc seen; parked until rst
//
// Every output comes straight from a register. im_addr and current_pc are
// both the PC register, so the request address is stable for free.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  DataSize = DataSizeDef,
  parameter int                  AddrSize = AddrSizeDef,
  parameter logic [AddrSize-1:0] RESET_PC = AddrSize'(ResetPcDef),
  parameter int                  TIMEOUT  = TimeoutDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [AddrSize-1:0] next_pc_i,
  input  logic                ir_ready_i,
  fetch_unit_if.master        imem,
  output logic [AddrSize-1:0] current_pc_o,
  output logic [DataSize-1:0] ir_o,
  output logic                ir_valid_o,
  output logic                timeout_err_o,
  output logic                misalign_err_o
);

  fetch_state_e        state_q, state_d;
  logic [AddrSize-1:0] pc_q, pc_d;
  logic [DataSize-1:0] ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic                im_req_q, im_req_d;
  logic                timeout_err_q, timeout_err_d;
  logic                misalign_err_q, misalign_err_d;

  logic                wdt_clear;
  logic                wdt_count;
  logic                wdt_expired;

  fetch_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (wdt_clear),
    .count_en_i (wdt_count),
    .expired_o  (wdt_expired)
  );

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    ir_valid_d     = ir_valid_q;
    im_req_d       = im_req_q;
    timeout_err_d  = timeout_err_q;
    misalign_err_d = misalign_err_q;
    wdt_clear      = 1'b0;
    wdt_count      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        im_req_d = 1'b0;
        if (enable_i) begin
          im_req_d  = 1'b1;
          wdt_clear = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        // An ack on the last permitted cycle still counts as success, so
        // it is checked ahead of the watchdog.
        if (imem.im_ack) begin
          ir_d       = imem.im_rdata;
          ir_valid_d = 1'b1;
          im_req_d   = 1'b0;
          state_d    = S_VALID;
        end else if (wdt_expired) begin
          im_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_ERR;
        end else begin
          wdt_count = 1'b1;
        end
      end

      S_VALID: begin
        if (ir_ready_i) begin
          ir_valid_d = 1'b0;
          if (!pc_aligned(next_pc_i[1:0])) begin
            // Keep the old PC so current_pc points at the last good fetch.
            misalign_err_d = 1'b1;
            state_d        = S_ERR;
          end else begin
            pc_d = next_pc_i;
            if (enable_i) begin
              im_req_d  = 1'b1;
              wdt_clear = 1'b1;
              state_d   = S_REQ;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_ERR: begin
        im_req_d   = 1'b0;
        ir_valid_d = 1'b0;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      ir_valid_q     <= 1'b0;
      im_req_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      ir_valid_q     <= ir_valid_d;
      im_req_q       <= im_req_d;
      timeout_err_q  <= timeout_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign imem.im_req    = im_req_q;
  assign imem.im_addr   = pc_q;
  assign current_pc_o   = pc_q;
  assign ir_o           = ir_q;
  assign ir_valid_o     = ir_valid_q;
  assign timeout_err_o  = timeout_err_q;
  assign misalign_err_o = misalign_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch, back-to-back, timeout,
// misalign, PC wrap and mid-transaction reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ir_ready;
  logic [9:0]  next_pc;
  logic [9:0]  current_pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        timeout_err;
  logic        misalign_err;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_unit_if #(.AddrSize(10), .DataSize(32)) imem_if ();

  fetch_unit #(
    .DataSize (32),
    .AddrSize (10),
    .RESET_PC (10'h000),
    .TIMEOUT  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .next_pc_i      (next_pc),
    .ir_ready_i     (ir_ready),
    .imem           (imem_if),
    .current_pc_o   (current_pc),
    .ir_o           (ir),
    .ir_valid_o     (ir_valid),
    .timeout_err_o  (timeout_err),
    .misalign_err_o (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   {31'd0, imem_if.im_req},  32'd0);
    check({tag, "_addr"},  {22'd0, imem_if.im_addr}, 32'h000);
    check({tag, "_pc"},    {22'd0, current_pc},      32'h000);
    check({tag, "_ir"},    ir,                       32'd0);
    check({tag, "_valid"}, {31'd0, ir_valid},        32'd0);
    check({tag, "_terr"},  {31'd0, timeout_err},     32'd0);
    check({tag, "_merr"},  {31'd0, misalign_err},    32'd0);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    enable           = 1'b0;
    ir_ready         = 1'b0;
    next_pc          = 10'h000;
    imem_if.im_ack   = 1'b0;
    imem_if.im_rdata = 32'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One fetch with a single-cycle memory. Called from S_IDLE, or from
  // S_VALID with ir_ready high so the first edge also consumes.
  task automatic fetch_one(input string tag, input logic [9:0] npc,
                           input logic [31:0] data, input logic [9:0] exp_pc);
    next_pc        = npc;
    imem_if.im_ack = 1'b0;
    step();
    check({tag, "_req"},      {31'd0, imem_if.im_req},  32'd1);
    check({tag, "_addr"},     {22'd0, imem_if.im_addr}, {22'd0, exp_pc});
    check({tag, "_valid0"},   {31'd0, ir_valid},        32'd0);
    imem_if.im_ack   = 1'b1;
    imem_if.im_rdata = data;
    step();
    imem_if.im_ack = 1'b0;
    check({tag, "_valid1"},   {31'd0, ir_valid},        32'd1);
    check({tag, "_ir"},       ir,                       data);
    check({tag, "_pc"},       {22'd0, current_pc},      {22'd0, exp_pc});
    check({tag, "_req_done"}, {31'd0, imem_if.im_req},  32'd0);
  endtask

  initial begin
    int req_high;
    logic [31:0] seq_data [3];
    seq_data[0] = 32'h0000_0011;
    seq_data[1] = 32'h0000_0022;
    seq_data[2] = 32'h0000_0033;

    // Reset values
    do_reset();
    check_reset_state("rst");

    // Single fetch, held while not consumed
    enable = 1'b1;
    fetch_one("t1", 10'h000, 32'hDEAD_BEEF, 10'h000);
    enable = 1'b0;
    step();
    check("t1_hold_valid", {31'd0, ir_valid}, 32'd1);
    check("t1_hold_ir",    ir,                32'hDEAD_BEEF);

    // Back-to-back fetches, two cycles per instruction
    do_reset();
    enable   = 1'b1;
    ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_one($sformatf("t2_%0d", i), 10'(i * 4), seq_data[i], 10'(i * 4));
    end
    // Consume with enable low: back to idle, no new request
    enable  = 1'b0;
    next_pc = 10'h00C;
    step();
    check("t2_idle_pc",    {22'd0, current_pc},     32'h00C);
    check("t2_idle_req",   {31'd0, imem_if.im_req}, 32'd0);
    check("t2_idle_valid", {31'd0, ir_valid},       32'd0);
    imem_if.im_ack = 1'b1;
    step();
    imem_if.im_ack = 1'b0;
    check("t2_ack_ignored", {31'd0, ir_valid}, 32'd0);

    // Timeout: no ack at all
    do_reset();
    enable = 1'b1;
    step();
    enable   = 1'b0;
    req_high = int'(imem_if.im_req);
    for (int k = 0; k < 19; k++) begin
      step();
      req_high += int'(imem_if.im_req);
    end
    check("t3_req_cycles", 32'(req_high),        32'd16);
    check("t3_terr",       {31'd0, timeout_err}, 32'd1);
    check("t3_valid",      {31'd0, ir_valid},    32'd0);
    enable = 1'b1;
    step();
    check("t3_err_no_req", {31'd0, imem_if.im_req}, 32'd0);

    // Ack on the last permitted cycle is a success
    do_reset();
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
    end
    check("t3b_req_still", {31'd0, imem_if.im_req}, 32'd1);
    imem_if.im_ack   = 1'b1;
    imem_if.im_rdata = 32'hCAFE_F00D;
    step();
    imem_if.im_ack = 1'b0;
    check("t3b_valid", {31'd0, ir_valid},    32'd1);
    check("t3b_ir",    ir,                   32'hCAFE_F00D);
    check("t3b_terr",  {31'd0, timeout_err}, 32'd0);

    // PC wrap from 0x3FC to 0x000
    do_reset();
    enable   = 1'b1;
    ir_ready = 1'b0;
    fetch_one("t5a", 10'h000, 32'h0000_00A0, 10'h000);
    ir_ready = 1'b1;
    fetch_one("t5b", 10'h3FC, 32'h0000_00A1, 10'h3FC);
    fetch_one("t5c", 10'h000, 32'h0000_00A2, 10'h000);

    // Misaligned next_pc
    fetch_one("t4a", 10'h004, 32'h0000_00B0, 10'h004);
    next_pc = 10'h3FE;
    step();
    check("t4_merr",  {31'd0, misalign_err},   32'd1);
    check("t4_pc",    {22'd0, current_pc},     32'h004);
    check("t4_valid", {31'd0, ir_valid},       32'd0);
    check("t4_req",   {31'd0, imem_if.im_req}, 32'd0);
    next_pc = 10'h008;
    step();
    step();
    check("t4_no_req",  {31'd0, imem_if.im_req}, 32'd0);
    check("t4_pc_hold", {22'd0, current_pc},     32'h004);
    check("t4_terr",    {31'd0, timeout_err},    32'd0);

    // Reset while a request is outstanding; a late ack is ignored
    do_reset();
    enable = 1'b1;
    step();
    check("t6_in_req", {31'd0, imem_if.im_req}, 32'd1);
    rst = 1'b1;
    step();
    check_reset_state("t6_rst_req");
    rst              = 1'b0;
    enable           = 1'b0;
    imem_if.im_ack   = 1'b1;
    imem_if.im_rdata = 32'h5555_AAAA;
    step();
    imem_if.im_ack = 1'b0;
    check("t6_late_ack_valid", {31'd0, ir_valid},       32'd0);
    check("t6_late_ack_req",   {31'd0, imem_if.im_req}, 32'd0);

    // Reset while holding an unconsumed instruction
    enable   = 1'b1;
    ir_ready = 1'b0;
    fetch_one("t6b", 10'h000, 32'h1234_5678, 10'h000);
    rst = 1'b1;
    step();
    check_reset_state("t6_rst_valid");
    rst = 1'b0;

    // enable dropped mid-request: fetch completes, then idle after consume
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    check("t6c_req_kept", {31'd0, imem_if.im_req}, 32'd1);
    imem_if.im_ack   = 1'b1;
    imem_if.im_rdata = 32'h0BAD_F00D;
    step();
    imem_if.im_ack = 1'b0;
    check("t6c_valid", {31'd0, ir_valid}, 32'd1);
    check("t6c_ir",    ir,                32'h0BAD_F00D);
    ir_ready = 1'b1;
    next_pc  = 10'h004;
    step();
    check("t6c_pc",    {22'd0, current_pc},     32'h004);
    check("t6c_idle",  {31'd0, imem_if.im_req}, 32'd0);
    check("t6c_clear", {31'd0, ir_valid},       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
